demux_1to8_buf: RTL

Registered 1-to-8 demultiplexer: the inverse of the 8:1 selector used in the immediate/operand path. A single 32-bit producer stream is steered by a 3-bit select to one of eight consumer lanes, for example write-back targets or per-format decode consumers. Each lane has a one-entry holding buffer with valid/ready flow control, so a stalled consumer blocks only its own lane. The block also counts the words it accepts.

---
 rtl/demux_1to8_buf.sv | 67 ++++++
 1 files changed

// File: rtl/demux_1to8_buf.sv
// Registered 1-to-8 demux with one-entry valid/ready buffer per lane.
// Optional DEMUX_ZERO_IDLE_EN: drive idle lanes' out_data to zero.
module demux_1to8_buf #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [2:0]          in_sel,
  output logic [7:0]          out_valid,
  input  logic [7:0]          out_ready,
  output logic [8*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]    acc_cnt
);

  logic [7:0]             valid_q, valid_d;
  logic [7:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             fire;
  logic                   acc;

  assign fire     = valid_q & out_ready;
  // Only the selected lane's ready reaches in_ready.
  assign in_ready = ~rst & (~valid_q[in_sel] | out_ready[in_sel]);
  assign acc      = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q & ~fire;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (acc) begin
      valid_d[in_sel] = 1'b1;
      data_d[in_sel]  = in_data;
      cnt_d           = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign acc_cnt   = cnt_q;

`ifdef DEMUX_ZERO_IDLE_EN
  always_comb begin
    out_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (valid_q[i]) out_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end
`else
  assign out_data = data_q;
`endif

endmodule
